// File: rtl/triangle_decoder_if.sv
// triangle_decoder_if -- sample stream in, decoded phase/period out.
//   master: drives in_valid/sample, observes decoder outputs (testbench/source side)
//   slave : the decoder itself
// Signals:
//   in_valid      sample qualifier, one cycle per accepted sample
//   sample[6:0]   triangle amplitude
//   phase_out[7:0] reconstructed phase (registered)
//   phase_valid   one-cycle pulse, phase_out updated
//   dir           0 = rising half, 1 = falling half
//   locked        direction known
//   period        accepted samples between the last two troughs (saturating)
//   period_valid  one-cycle pulse, period updated
interface triangle_decoder_if #(
  parameter int PERIOD_W = 16
);
  logic                in_valid;
  logic [6:0]          sample;
  logic [7:0]          phase_out;
  logic                phase_valid;
  logic                dir;
  logic                locked;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;

  modport master (
    output in_valid, sample,
    input  phase_out, phase_valid, dir, locked, period, period_valid
  );

  modport slave (
    input  in_valid, sample,
    output phase_out, phase_valid, dir, locked, period, period_valid
  );
endinterface

// File: rtl/triangle_decoder.sv
// triangle_decoder -- recovers an 8-bit phase from a 7-bit triangle amplitude
// stream and measures the waveform period in accepted samples.
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset (wins over in_valid)
//   bus  triangle_decoder_if.slave (see interface file for signal list)
// Parameter:
//   PERIOD_W  width of the period counter/output (4..24)
module triangle_decoder #(
  parameter int PERIOD_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  triangle_decoder_if.slave    bus
);

  typedef enum logic [1:0] {
    UNLOCK  = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2
  } state_t;

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

  state_t              r_state;
  state_t              w_state_next;
  logic [6:0]          r_prev;
  logic                r_have_prev;
  logic                r_seen_trough;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] r_period;
  logic                r_period_valid;
  logic [7:0]          r_phase_out;
  logic                r_phase_valid;
  logic                r_dir;
  logic                r_locked;
  logic                w_trough;
  logic                w_report;

  // Direction tracking. Equal neighbours never change state, so the
  // duplicated peak/trough code is reported as 127/255 rather than 128/0.
  always_comb begin
    w_state_next = r_state;
    w_trough     = 1'b0;
    if (bus.in_valid && r_have_prev) begin
      case (r_state)
        UNLOCK: begin
          if (bus.sample > r_prev)      w_state_next = RISING;
          else if (bus.sample < r_prev) w_state_next = FALLING;
        end
        RISING: begin
          if (bus.sample < r_prev) w_state_next = FALLING;
        end
        FALLING: begin
          if (bus.sample > r_prev) begin
            w_state_next = RISING;
            w_trough     = 1'b1;
          end
        end
        default: w_state_next = UNLOCK;
      endcase
    end
  end

  assign w_report = bus.in_valid && r_have_prev && (w_state_next != UNLOCK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= UNLOCK;
      r_prev         <= '0;
      r_have_prev    <= 1'b0;
      r_seen_trough  <= 1'b0;
      r_cnt          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_phase_out    <= '0;
      r_phase_valid  <= 1'b0;
      r_dir          <= 1'b0;
      r_locked       <= 1'b0;
    end else begin
      r_phase_valid  <= 1'b0;
      r_period_valid <= 1'b0;
      if (bus.in_valid) begin
        r_prev      <= bus.sample;
        r_have_prev <= 1'b1;
        r_state     <= w_state_next;
        r_locked    <= (w_state_next != UNLOCK);

        if (w_report) begin
          // Falling half carries the inverted phase LSBs.
          r_phase_out   <= (w_state_next == FALLING) ? {1'b1, ~bus.sample}
                                                     : {1'b0, bus.sample};
          r_dir         <= (w_state_next == FALLING);
          r_phase_valid <= 1'b1;
        end

        if (w_trough) begin
          r_cnt         <= '0;
          r_seen_trough <= 1'b1;
          // The first trough only starts the measurement window.
          if (r_seen_trough) begin
            r_period       <= (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
            r_period_valid <= 1'b1;
          end
        end else if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.phase_out    = r_phase_out;
  assign bus.phase_valid  = r_phase_valid;
  assign bus.dir          = r_dir;
  assign bus.locked       = r_locked;
  assign bus.period       = r_period;
  assign bus.period_valid = r_period_valid;

endmodule

// File: tb/tb_triangle_decoder.sv
// tb_triangle_decoder -- directed-vector bench for triangle_decoder.
// One 16-bit-period instance runs the phase/period/gap/reset streams; a
// PERIOD_W=4 instance checks period saturation.
module tb_triangle_decoder;

  logic clk;
  logic rst;

  triangle_decoder_if #(.PERIOD_W(16)) bus16 ();
  triangle_decoder_if #(.PERIOD_W(4))  bus4 ();

  triangle_decoder #(.PERIOD_W(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  triangle_decoder #(.PERIOD_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Expected-value state for the 16-bit instance.
  int          acc_since_rst = 0;
  bit          mdl_seen      = 0;
  logic [31:0] exp_period    = 0;
  logic [7:0]  exp_phase     = 0;

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Encoder: phase k (0..255) -> 7-bit triangle amplitude.
  function automatic logic [6:0] enc(input int k);
    logic [7:0] p;
    p = k[7:0];
    return p[7] ? ~p[6:0] : p[6:0];
  endfunction

  // Expected reported phase for stream position k once locked.
  function automatic logic [7:0] phase_of(input int k);
    if (k == 128) return 8'd127;
    if (k == 0)   return 8'd255;
    return k[7:0];
  endfunction

  // One clock of the 16-bit stream: v = in_valid, r = rst, k = phase index.
  task automatic step16(input bit v, input bit r, input int k, input logic [6:0] smp);
    bit report, trough, pulse;
    @(negedge clk);
    rst            = r;
    bus16.in_valid = v;
    bus16.sample   = smp;
    @(posedge clk);
    #1;
    report = 0;
    pulse  = 0;
    if (r) begin
      acc_since_rst = 0;
      mdl_seen      = 0;
      exp_period    = 0;
      exp_phase     = 0;
      check_value("rst_phase_out", {24'd0, bus16.phase_out}, 0);
      check_value("rst_phase_valid", {31'd0, bus16.phase_valid}, 0);
      check_value("rst_dir", {31'd0, bus16.dir}, 0);
      check_value("rst_locked", {31'd0, bus16.locked}, 0);
      check_value("rst_period", {16'd0, bus16.period}, 0);
      check_value("rst_period_valid", {31'd0, bus16.period_valid}, 0);
    end else if (v) begin
      report = (acc_since_rst >= 1);
      trough = (k == 1) && (acc_since_rst >= 2);
      pulse  = trough && mdl_seen;
      if (trough) mdl_seen = 1;
      if (pulse) exp_period = 256;
      if (report) exp_phase = phase_of(k);
      acc_since_rst++;
      check_value("phase_valid", {31'd0, bus16.phase_valid}, {31'd0, report});
      if (report) begin
        check_value("phase_out", {24'd0, bus16.phase_out}, {24'd0, exp_phase});
        check_value("dir", {31'd0, bus16.dir}, {31'd0, exp_phase[7]});
      end
      check_value("locked", {31'd0, bus16.locked}, {31'd0, acc_since_rst >= 2});
      check_value("period_valid", {31'd0, bus16.period_valid}, {31'd0, pulse});
      check_value("period", {16'd0, bus16.period}, exp_period);
    end else begin
      check_value("idle_phase_valid", {31'd0, bus16.phase_valid}, 0);
      check_value("idle_period_valid", {31'd0, bus16.period_valid}, 0);
      check_value("idle_phase_hold", {24'd0, bus16.phase_out}, {24'd0, exp_phase});
      check_value("idle_period_hold", {16'd0, bus16.period}, exp_period);
    end
    $display("t=%0t rst=%0b v=%0b k=%0d smp=%0d -> phase=%0d pv=%0b dir=%0b lk=%0b per=%0d perv=%0b",
             $time, r, v, k, smp, bus16.phase_out, bus16.phase_valid, bus16.dir,
             bus16.locked, bus16.period, bus16.period_valid);
  endtask

  // Small triangle with 40 samples per cycle: 0..20 up, 19..1 down.
  function automatic logic [6:0] tri40(input int j);
    int m;
    m = j % 40;
    return (m <= 20) ? m[6:0] : 7'(40 - m);
  endfunction

  task automatic step4(input int j);
    bit pulse;
    logic [31:0] exp4;
    @(negedge clk);
    bus4.in_valid = 1'b1;
    bus4.sample   = tri40(j);
    @(posedge clk);
    #1;
    pulse = ((j % 40) == 1) && (j >= 81);
    exp4  = (j >= 81) ? 32'd15 : 32'd0;
    check_value("sat_period_valid", {31'd0, bus4.period_valid}, {31'd0, pulse});
    check_value("sat_period", {28'd0, bus4.period}, exp4);
    check_value("sat_locked", {31'd0, bus4.locked}, {31'd0, j >= 1});
    $display("t=%0t sat j=%0d smp=%0d -> per=%0d perv=%0b lk=%0b",
             $time, j, tri40(j), bus4.period, bus4.period_valid, bus4.locked);
  endtask

  initial begin
    int g;
    rst            = 1'b1;
    bus16.in_valid = 1'b0;
    bus16.sample   = '0;
    bus4.in_valid  = 1'b0;
    bus4.sample    = '0;

    // Reset held two cycles while a valid sample is presented.
    step16(1, 1, 0, 7'h55);
    step16(1, 1, 0, 7'h55);

    // Continuous ramp: three full waveform cycles.
    for (g = 0; g < 768; g++) step16(1, 0, g % 256, enc(g % 256));

    // Same stream with idle cycles interleaved.
    for (g = 768; g < 1280; g++) begin
      step16(1, 0, g % 256, enc(g % 256));
      step16(0, 0, g % 256, 7'h00);
    end

    // Run to sample 200, reset there, then resume from sample 200.
    for (g = 1280; g < 1480; g++) step16(1, 0, g % 256, enc(g % 256));
    step16(1, 1, 200, enc(200));
    for (g = 1480; g < 1480 + 2 * 256 + 8; g++) step16(1, 0, g % 256, enc(g % 256));

    // Saturation on the narrow instance.
    @(negedge clk);
    bus16.in_valid = 1'b0;
    rst            = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_value("sat_rst_period", {28'd0, bus4.period}, 0);
    for (int j = 0; j < 126; j++) step4(j);
    @(negedge clk);
    bus4.in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/triangle_decoder.md
TRIANGLE_DECODER -- requirements
Module: triangle_decoder

Interface
REQ-001 The block SHALL have one parameter: PERIOD_W, default 16, width of period counter and period output (legal range 4..24).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on rising clk.
REQ-004 in_valid  input  1  qualifies sample for one cycle; sample accepted on any clk edge with in_valid=1.
REQ-005 sample  input  7  triangle amplitude: rising half carries phase[6:0], falling half carries ~phase[6:0].
REQ-006 phase_out  output  8  reconstructed 8-bit phase, registered.
REQ-007 phase_valid  output  1  one-cycle pulse; phase_out is new this cycle.
REQ-008 dir  output  1  0 = rising half, 1 = falling half.
REQ-009 locked  output  1  high once direction is known (state RISING or FALLING).
REQ-010 period  output  PERIOD_W  accepted samples between the last two troughs, saturating.
REQ-011 period_valid  output  1  one-cycle pulse; period is new this cycle.

Function
REQ-012 Internal state: FSM {UNLOCK, RISING, FALLING}, prev[6:0], have_prev flag, seen_trough flag, cnt[PERIOD_W-1:0].
REQ-013 Cycles with in_valid=0 SHALL change no state; phase_valid and period_valid SHALL be 0; other outputs hold.
REQ-014 First accepted sample after reset: store into prev, set have_prev, stay UNLOCK, phase_valid=0.
REQ-015 Every later accepted sample: compare against prev, compute next state, then prev <= sample.
REQ-016 UNLOCK: sample>prev -> RISING; sample<prev -> FALLING; equal -> stay UNLOCK.
REQ-017 RISING: sample<prev -> FALLING (peak); otherwise stay.
REQ-018 FALLING: sample>prev -> RISING (trough event); otherwise stay.
REQ-019 On an accepted sample whose next state is RISING or FALLING: phase_out <= {0,sample} for RISING, {1,~sample} for FALLING; dir <= (next==FALLING); phase_valid <= 1; all one cycle after the accepting edge.
REQ-020 Equal consecutive samples SHALL keep state, so the duplicated peak/trough code reports phase 127 (resp. 255) twice; phase 128 and phase 0 are never reported.
REQ-021 locked SHALL equal (state != UNLOCK), registered with the state.
REQ-022 cnt SHALL increment, saturating at 2^PERIOD_W-1, on each accepted sample that is not a trough event.
REQ-023 On a trough event: cnt <= 0; seen_trough <= 1; if seen_trough was already 1, period <= min(cnt+1, 2^PERIOD_W-1) and period_valid <= 1 next cycle.
REQ-024 First trough after reset SHALL NOT pulse period_valid.
REQ-025 Peak and trough in consecutive accepted samples are legal; each is processed independently per REQ-017/018.

Reset
REQ-026 With rst=1 at a clk edge: state=UNLOCK, prev=0, have_prev=0, seen_trough=0, cnt=0, phase_out=0, dir=0, locked=0, period=0, phase_valid=0, period_valid=0.
REQ-027 rst SHALL take priority over in_valid in the same cycle; sample presented then is discarded.
REQ-028 Reset mid-waveform SHALL fully relock: next accepted sample is treated as first per REQ-014.

Verification
REQ-029 Reset: hold rst 2 cycles with in_valid=1, sample=0x55 -> all outputs 0, no pulses; first post-reset sample produces no phase_valid.
REQ-030 Ramp: feed encoder of phase 0..255 continuously (samples 0,1..127,127,126..0) -> phase_out 1..127, 127, 129..255; dir rises to 1 with phase_out=129; locked from second sample.
REQ-031 Period: continuous triangle, 256 samples/cycle, in_valid=1 every cycle -> first trough no pulse, each later trough period=256 with one-cycle period_valid.
REQ-032 Gaps: same stream with in_valid toggled 1,0,1,0 -> identical phase_out sequence and period=256; no pulses on idle cycles.
REQ-033 Saturation: PERIOD_W=4, troughs 40 samples apart -> period=15.
REQ-034 Mid-run reset: assert rst at sample 200 of a cycle, resume stream -> locked=0 until first differing sample, no period_valid until second trough after reset.
